fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch for the LEGv8 core.
//  Issues req/ready requests to instruction memory and presents fetched words to decode.
//  Computes branch targets from 19/26-bit offsets on redirect, then inserts flush bubbles.
//  Sits between the execute-stage branch resolver/hazard unit and instruction memory.
// PARAMETERS
//  ADDR_W        64  PC / memory address width
//  RESET_PC      0   PC value loaded on reset
//  FLUSH_CYCLES  1   bubble cycles after a taken branch, legal range 1..15
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       asynchronous, active-low reset (0 = in reset)
//  stall        in   1       hazard unit: hold fetch and IF/ID outputs
//  br_taken     in   1       one-cycle redirect pulse from execute
//  uncond_br    in   1       1: use br_addr26, 0: use cond_addr19
//  cond_addr19  in   19      signed word offset (CB-type)
//  br_addr26    in   26      signed word offset (B-type)
//  br_pc        in   ADDR_W  PC of the resolving branch instruction
//  imem_req     out  1       fetch request
//  imem_addr    out  ADDR_W  fetch address, equals pc
//  imem_ready   in   1       memory accepts req and returns imem_rdata in the same cycle
//  imem_rdata   in   32      instruction word
//  if_valid     out  1       if_instr/if_pc hold a valid instruction
//  if_instr     out  32      registered instruction to decode
//  if_pc        out  ADDR_W  PC of if_instr
//  flush        out  1       kill younger in-flight instructions
//  pc           out  ADDR_W  current fetch PC
// BEHAVIOUR
//  Reset (async, reset=0): pc=RESET_PC; if_valid=0, if_instr=0, if_pc=0; flush=0;
//   state=FETCH, flush counter=0. imem_req is forced to 0 while reset=0.
//  States: FETCH, STALL, FLUSH. imem_req=1 only in FETCH with stall=0 and br_taken=0.
//  Accept = imem_req & imem_ready. On accept: if_instr<=imem_rdata, if_pc<=pc,
//   if_valid<=1, pc<=pc+4. Fetch latency is 1 cycle from accept to if_valid.
//  FETCH with req and no ready: pc held, req held, if_valid<=0 (bubble).
//  stall=1 (no br_taken): go to STALL; pc, if_valid, if_instr and if_pc hold.
//   No request is issued. Return to FETCH in the first cycle with stall=0.
//  br_taken=1: highest priority in any state, overrides stall and imem_ready.
//   - offset = uncond_br ? sext(br_addr26) : sext(cond_addr19), extended to ADDR_W.
//   - Update pc<=br_pc+(offset<<2) and if_valid<=0; enter FLUSH with counter=FLUSH_CYCLES.
//   - Any imem_ready in that cycle is ignored.
//  FLUSH: flush=1, imem_req=0, if_valid=0. The counter decrements each cycle;
//   at 1 -> FETCH. br_taken during FLUSH reloads the target and the counter.
//   stall during FLUSH is ignored; the flush always completes.
//  flush is 1 exactly for the FLUSH_CYCLES cycles spent in FLUSH.
//  Arithmetic is modulo 2^ADDR_W: pc+4 and the target wrap silently, no fault.
//  imem_addr = pc at all times; imem_addr[1:0] is always 0 when RESET_PC is word-aligned.
//  A reset asserted mid-fetch or mid-flush aborts immediately and restores reset values.
// TESTING
//  1) Reset release, imem_ready=1 always -> pc 0,4,8,...; if_pc lags pc by one; if_valid=1 from cycle 2.
//  2) imem_ready=0 for 3 cycles at pc=8 -> imem_req=1 and pc=8 held; if_valid=0 for those cycles.
//  3) br_taken, uncond_br=0, cond_addr19=19'h7FFFF, br_pc=0x100 -> pc=0xFC; flush=1 for FLUSH_CYCLES.
//  4) br_taken, uncond_br=1, br_addr26=26'h10, br_pc=0x40 -> pc=0x80; next fetch addr=0x80.
//  5) stall=1 together with br_taken=1 -> redirect taken. Next: stall=1 for 2 cycles -> outputs frozen.
//  6) br_pc=64'hFFFF_FFFF_FFFF_FFF0, offset +8 -> pc wraps to 0x10. reset=0 mid-FLUSH -> all outputs at reset values.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch channel: the sequencer drives request/address,
// memory answers with ready and the instruction word in the same cycle.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 64
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer.sv
// LEGv8 fetch stage: owns the PC, issues instruction fetches, registers the
// fetched word for decode and redirects/flushes on taken branches.
module fetch_sequencer #(
    parameter int                ADDR_W       = 64,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic              uncond_br,
    input  logic [18:0]       cond_addr19,
    input  logic [25:0]       br_addr26,
    input  logic [ADDR_W-1:0] br_pc,
    fetch_sequencer_if.master imem,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              flush,
    output logic [ADDR_W-1:0] pc
);
    typedef enum logic [1:0] {S_FETCH, S_STALL, S_FLUSH} state_t;

    // Word offsets are sign-extended to the PC width and scaled to bytes; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] branch_target(
        input logic [ADDR_W-1:0] base,
        input logic              sel_b,
        input logic [18:0]       off19,
        input logic [25:0]       off26
    );
        logic signed [ADDR_W-1:0] off;
        off = sel_b ? {{(ADDR_W-26){off26[25]}}, off26}
                    : {{(ADDR_W-19){off19[18]}}, off19};
        return base + $unsigned(off <<< 2);
    endfunction

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic [ADDR_W-1:0] r_pc;
    logic              r_if_valid;
    logic [31:0]       r_if_instr;
    logic [ADDR_W-1:0] r_if_pc;
    logic              w_req;
    logic              w_accept;
    logic              w_flush;
    logic [ADDR_W-1:0] w_target;

    assign w_target = branch_target(br_pc, uncond_br, cond_addr19, br_addr26);
    assign w_accept = w_req & imem.imem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_req        = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req = !stall && !br_taken;
                if (stall) w_next_state = S_STALL;
            end
            S_STALL: begin
                if (!stall) w_next_state = S_FETCH;
            end
            S_FLUSH: begin
                w_flush = 1'b1;
                if (r_cnt <= 4'd1) w_next_state = S_FETCH;
                else               w_cnt_next   = r_cnt - 4'd1;
            end
            default: w_next_state = S_FETCH;
        endcase
        // A redirect wins over stall, ready and an in-progress flush.
        if (br_taken) begin
            w_next_state = S_FLUSH;
            w_cnt_next   = 4'(FLUSH_CYCLES);
        end
        w_req = w_req && reset;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else if (br_taken) begin
            r_pc       <= w_target;
            r_if_valid <= 1'b0;
        end else if (w_accept) begin
            r_if_instr <= imem.imem_rdata;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
            r_pc       <= r_pc + ADDR_W'(4);
        end else if (w_req || r_state == S_FLUSH) begin
            r_if_valid <= 1'b0;
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign if_valid       = r_if_valid;
    assign if_instr       = r_if_instr;
    assign if_pc          = r_if_pc;
    assign flush          = w_flush;
    assign pc             = r_pc;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a cycle model predicts PC/flush/request
// behaviour and a queue holds the instruction/PC pairs expected at the IF/ID outputs.
module tb_fetch_sequencer;
    localparam int ADDR_W  = 64;
    localparam int FC      = 2;
    localparam int S_FETCH = 0;
    localparam int S_STALL = 1;
    localparam int S_FLUSH = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              br_taken;
    logic              uncond_br;
    logic [18:0]       cond_addr19;
    logic [25:0]       br_addr26;
    logic [ADDR_W-1:0] br_pc;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              flush;
    logic [ADDR_W-1:0] pc;

    fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_sequencer #(
        .ADDR_W      (ADDR_W),
        .RESET_PC    (64'h0),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .uncond_br  (uncond_br),
        .cond_addr19(cond_addr19),
        .br_addr26  (br_addr26),
        .br_pc      (br_pc),
        .imem       (bus),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .flush      (flush),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    int                n_checks = 0;
    int                n_errors = 0;
    int                m_state;
    int                m_cnt;
    logic [ADDR_W-1:0] m_pc;
    logic              m_fresh;
    logic [31:0]       last_instr;
    logic [95:0]       sb[$];

    task automatic model_reset();
        m_state    = S_FETCH;
        m_cnt      = 0;
        m_pc       = 64'h0;
        m_fresh    = 1'b0;
        last_instr = 32'h0;
        sb.delete();
    endtask

    task automatic drive(input logic st, input logic br, input logic unc,
                         input logic [18:0] c19, input logic [25:0] a26,
                         input logic [ADDR_W-1:0] bpc, input logic rdy, input logic [31:0] rd);
        stall          = st;
        br_taken       = br;
        uncond_br      = unc;
        cond_addr19    = c19;
        br_addr26      = a26;
        br_pc          = bpc;
        bus.imem_ready = rdy;
        bus.imem_rdata = rd;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 1'b0, 19'h0, 26'h0, 64'h0, rdy, $urandom());
    endtask

    // Advance the model across one rising edge, then return on the falling edge.
    task automatic tick();
        logic              req;
        logic signed [63:0] off;
        @(posedge clk);
        if (reset !== 1'b1) begin
            model_reset();
        end else begin
            req     = (m_state == S_FETCH) && !stall && !br_taken;
            m_fresh = 1'b0;
            if (br_taken) begin
                if (uncond_br) off = $signed(br_addr26);
                else           off = $signed(cond_addr19);
                m_pc    = br_pc + off * 64'sd4;
                m_state = S_FLUSH;
                m_cnt   = FC;
            end else begin
                if (req && bus.imem_ready) begin
                    sb.push_back({bus.imem_rdata, m_pc});
                    last_instr = bus.imem_rdata;
                    m_pc       = m_pc + 64'd4;
                    m_fresh    = 1'b1;
                end
                case (m_state)
                    S_FETCH: if (stall) m_state = S_STALL;
                    S_STALL: if (!stall) m_state = S_FETCH;
                    default: begin
                        if (m_cnt <= 1) m_state = S_FETCH;
                        else            m_cnt   = m_cnt - 1;
                    end
                endcase
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b0;
        model_reset();
        idle(1'b1);
        tick();
        tick();
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        logic [95:0] exp_e;
        if (reset === 1'b1 && m_fresh) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL sb_underflow: got if_valid=%b if_pc=%h, no expected entry", if_valid, if_pc);
            end else begin
                exp_e = sb.pop_front();
                if ({if_valid, if_instr, if_pc} !== {1'b1, exp_e}) begin
                    n_errors++;
                    $display("FAIL sb_ifid: got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h",
                             if_valid, if_instr, if_pc, exp_e[95:64], exp_e[63:0]);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 19'h0, 26'h0, 64'h0, 1'b1, 32'hDEAD_BEEF);
        tick();
        tick();
        #1;
        n_checks++;
        if (pc !== 64'h0 || bus.imem_addr !== 64'h0) begin
            n_errors++; $display("FAIL reset_pc: got pc=%h addr=%h want 0", pc, bus.imem_addr);
        end
        n_checks++;
        if ({if_valid, if_instr, if_pc} !== 97'h0) begin
            n_errors++; $display("FAIL reset_ifid: got v=%b instr=%h pc=%h want 0", if_valid, if_instr, if_pc);
        end
        n_checks++;
        if (flush !== 1'b0 || bus.imem_req !== 1'b0) begin
            n_errors++; $display("FAIL reset_ctrl: got flush=%b req=%b want 0 0", flush, bus.imem_req);
        end
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            #1;
            n_checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'(i * 4)) begin
                n_errors++; $display("FAIL seq_req: got req=%b addr=%h want 1 %h", bus.imem_req, bus.imem_addr, 64'(i * 4));
            end
            tick();
            n_checks++;
            if (pc !== m_pc || pc !== 64'((i + 1) * 4)) begin
                n_errors++; $display("FAIL seq_pc: got %h want %h", pc, 64'((i + 1) * 4));
            end
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 64'(i * 4)) begin
                n_errors++; $display("FAIL seq_ifpc: got v=%b if_pc=%h want 1 %h", if_valid, if_pc, 64'(i * 4));
            end
        end
    endtask

    task automatic test_ready_gap();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            idle(1'b1);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            #1;
            n_checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h8) begin
                n_errors++; $display("FAIL gap_req: got req=%b addr=%h want 1 8", bus.imem_req, bus.imem_addr);
            end
            tick();
            n_checks++;
            if (pc !== 64'h8 || if_valid !== 1'b0) begin
                n_errors++; $display("FAIL gap_hold: got pc=%h v=%b want 8 0", pc, if_valid);
            end
        end
        idle(1'b1);
        tick();
        n_checks++;
        if (pc !== 64'hC || if_valid !== 1'b1 || if_pc !== 64'h8) begin
            n_errors++; $display("FAIL gap_resume: got pc=%h v=%b if_pc=%h want c 1 8", pc, if_valid, if_pc);
        end
    endtask

    task automatic test_cond_branch();
        int nflush;
        drive(1'b0, 1'b1, 1'b0, 19'h7FFFF, 26'h0, 64'h100, 1'b1, 32'h1234_5678);
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b0) begin
            n_errors++; $display("FAIL cbr_req: got req=%b want 0", bus.imem_req);
        end
        tick();
        n_checks++;
        if (pc !== 64'hFC || flush !== 1'b1 || if_valid !== 1'b0) begin
            n_errors++; $display("FAIL cbr_target: got pc=%h flush=%b v=%b want fc 1 0", pc, flush, if_valid);
        end
        nflush = 0;
        for (int k = 0; k < FC + 2; k++) begin
            idle(1'b1);
            #1;
            if (flush === 1'b1) nflush++;
            n_checks++;
            if (flush !== (m_state == S_FLUSH) || bus.imem_req !== (m_state == S_FETCH) || bus.imem_addr !== m_pc) begin
                n_errors++; $display("FAIL cbr_seq: got flush=%b req=%b addr=%h want %b %b %h", flush, bus.imem_req,
                                     bus.imem_addr, m_state == S_FLUSH, m_state == S_FETCH, m_pc);
            end
            tick();
        end
        n_checks++;
        if (nflush != FC || pc !== 64'h104) begin
            n_errors++; $display("FAIL cbr_flushlen: got flush_cycles=%0d pc=%h want %0d 104", nflush, pc, FC);
        end
    endtask

    task automatic test_uncond_branch();
        drive(1'b0, 1'b1, 1'b1, 19'h0, 26'h10, 64'h40, 1'b0, 32'h0);
        tick();
        n_checks++;
        if (pc !== 64'h80) begin
            n_errors++; $display("FAIL ubr_target: got %h want 80", pc);
        end
        for (int k = 0; k < FC; k++) begin
            idle(1'b1);
            #1;
            n_checks++;
            if (flush !== 1'b1 || bus.imem_req !== 1'b0) begin
                n_errors++; $display("FAIL ubr_flush: got flush=%b req=%b want 1 0", flush, bus.imem_req);
            end
            tick();
        end
        idle(1'b1);
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h80 || flush !== 1'b0) begin
            n_errors++; $display("FAIL ubr_fetch: got req=%b addr=%h flush=%b want 1 80 0", bus.imem_req, bus.imem_addr, flush);
        end
        tick();
    endtask

    task automatic test_flush_reload();
        int nflush;
        drive(1'b0, 1'b1, 1'b1, 19'h0, 26'h10, 64'h0, 1'b1, 32'h0);
        tick();
        idle(1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 19'h7FFF0, 26'h0, 64'h200, 1'b1, 32'h0);
        tick();
        n_checks++;
        if (pc !== 64'h1C0 || flush !== 1'b1) begin
            n_errors++; $display("FAIL reload_target: got pc=%h flush=%b want 1c0 1", pc, flush);
        end
        nflush = 0;
        for (int k = 0; k < FC + 1; k++) begin
            idle(1'b1);
            #1;
            if (flush === 1'b1) nflush++;
            tick();
        end
        n_checks++;
        if (nflush != FC || pc !== 64'h1C4 || if_pc !== 64'h1C0) begin
            n_errors++; $display("FAIL reload_len: got flush_cycles=%0d pc=%h if_pc=%h want %0d 1c4 1c0",
                                 nflush, pc, if_pc, FC);
        end
    endtask

    task automatic test_stall_branch();
        int nflush;
        drive(1'b1, 1'b1, 1'b0, 19'd4, 26'h0, 64'h300, 1'b1, 32'h0);
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b0) begin
            n_errors++; $display("FAIL stbr_req: got %b want 0", bus.imem_req);
        end
        tick();
        n_checks++;
        if (pc !== 64'h310 || flush !== 1'b1) begin
            n_errors++; $display("FAIL stbr_target: got pc=%h flush=%b want 310 1", pc, flush);
        end
        nflush = 0;
        for (int k = 0; k < FC; k++) begin
            drive(1'b1, 1'b0, 1'b0, 19'h0, 26'h0, 64'h0, 1'b1, $urandom());
            #1;
            if (flush === 1'b1) nflush++;
            tick();
        end
        n_checks++;
        if (nflush != FC || flush !== 1'b0) begin
            n_errors++; $display("FAIL stbr_flush: got flush_cycles=%0d flush=%b want %0d 0", nflush, flush, FC);
        end
        for (int k = 0; k < 2; k++) begin
            idle(1'b1);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 19'h0, 26'h0, 64'h0, 1'b1, $urandom());
            #1;
            n_checks++;
            if (bus.imem_req !== 1'b0) begin
                n_errors++; $display("FAIL stall_req: got %b want 0", bus.imem_req);
            end
            tick();
            n_checks++;
            if (pc !== 64'h318 || if_valid !== 1'b1 || if_pc !== 64'h314 || if_instr !== last_instr) begin
                n_errors++; $display("FAIL stall_hold: got pc=%h v=%b if_pc=%h instr=%h want 318 1 314 %h",
                                     pc, if_valid, if_pc, if_instr, last_instr);
            end
        end
        idle(1'b1);
        #1;
        n_checks++;
        if (bus.imem_req !== ((m_state == S_FETCH) && !stall && !br_taken)) begin
            n_errors++; $display("FAIL stall_exit_req: got %b want %b", bus.imem_req, m_state == S_FETCH);
        end
        tick();
        idle(1'b1);
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h318) begin
            n_errors++; $display("FAIL stall_resume: got req=%b addr=%h want 1 318", bus.imem_req, bus.imem_addr);
        end
        tick();
    endtask

    task automatic test_wrap_reset();
        drive(1'b0, 1'b1, 1'b0, 19'h7FFFF, 26'h0, 64'h0, 1'b1, 32'h0);
        tick();
        for (int k = 0; k < FC; k++) begin
            idle(1'b1);
            tick();
        end
        idle(1'b1);
        #1;
        n_checks++;
        if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC || bus.imem_req !== 1'b1) begin
            n_errors++; $display("FAIL wrap_addr: got addr=%h req=%b want fffffffffffffffc 1", bus.imem_addr, bus.imem_req);
        end
        tick();
        n_checks++;
        if (pc !== 64'h0 || if_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_errors++; $display("FAIL wrap_inc: got pc=%h if_pc=%h want 0 fffffffffffffffc", pc, if_pc);
        end
        drive(1'b0, 1'b1, 1'b0, 19'd8, 26'h0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 32'h0);
        tick();
        n_checks++;
        if (pc !== 64'h10 || flush !== 1'b1) begin
            n_errors++; $display("FAIL wrap_target: got pc=%h flush=%b want 10 1", pc, flush);
        end
        idle(1'b1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (pc !== 64'h0 || flush !== 1'b0 || bus.imem_req !== 1'b0) begin
            n_errors++; $display("FAIL midflush_reset_ctrl: got pc=%h flush=%b req=%b want 0 0 0", pc, flush, bus.imem_req);
        end
        n_checks++;
        if ({if_valid, if_instr, if_pc} !== 97'h0) begin
            n_errors++; $display("FAIL midflush_reset_ifid: got v=%b instr=%h pc=%h want 0", if_valid, if_instr, if_pc);
        end
        tick();
        reset = 1'b1;
        idle(1'b1);
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin
            n_errors++; $display("FAIL post_reset_fetch: got req=%b addr=%h want 1 0", bus.imem_req, bus.imem_addr);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ready_gap();
        test_cond_branch();
        test_uncond_branch();
        test_flush_reload();
        test_stall_branch();
        test_wrap_reset();
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++; $display("FAIL sb_leftover: got %0d pending entries want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
